// File: rtl/file_op_exec.sv
// Byte-oriented file-register instruction executor: fetches operand, computes,
// and writes back to the register file or W over a fixed four-state sequence.
//   state | meaning
//   IDLE  | ready for a new instruction
//   RD    | drive effective address, latch operand
//   EX    | compute result, flags, write/skip decisions
//   WB    | commit to register file or W, pulse done
module file_op_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [11:0] instr,
  output logic        instr_ready,
  input  logic [4:0]  fsr,
  input  logic [7:0]  f_out_data,
  input  logic        C,
  output logic [4:0]  f_adrs,
  output logic        f_wr,
  output logic [7:0]  f_in_data,
  output logic        C_new,
  output logic        DC_new,
  output logic        Z_new,
  output logic        C_en,
  output logic        DC_en,
  output logic        Z_en,
  output logic [7:0]  W,
  output logic        skip,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RD, EX, WB} state_t;

  state_t      state;
  logic [11:0] instr_q;
  logic [4:0]  eff_adr;
  logic [7:0]  operand, result;
  logic        c_q, dc_q, z_q;
  logic        c_en_q, dc_en_q, z_en_q;
  logic        f_wr_q, w_wr_q, skip_q, done_q;

  logic [5:0]  op;
  logic        d;
  logic [4:0]  ea_rd;
  logic [8:0]  add9, sub9;
  logic [4:0]  add5, sub5;

  logic [7:0]  res_n;
  logic        c_n, dc_n, c_e, dc_e, z_e, wr_n, skp_n;

  assign op    = instr_q[11:6];
  assign d     = instr_q[5];
  assign ea_rd = (instr_q[4:0] == 5'd0) ? fsr : instr_q[4:0];

  // Subtraction is two's complement add; carry out means "no borrow".
  assign add9 = {1'b0, operand} + {1'b0, W};
  assign add5 = {1'b0, operand[3:0]} + {1'b0, W[3:0]};
  assign sub9 = {1'b0, operand} + {1'b0, ~W} + 9'd1;
  assign sub5 = {1'b0, operand[3:0]} + {1'b0, ~W[3:0]} + 5'd1;

  always_comb begin
    res_n = operand;
    c_n   = 1'b0;
    dc_n  = 1'b0;
    c_e   = 1'b0;
    dc_e  = 1'b0;
    z_e   = 1'b0;
    wr_n  = 1'b1;
    skp_n = 1'b0;
    case (op)
      6'b000000: begin res_n = W; wr_n = d; end
      6'b000001: begin res_n = 8'h00; z_e = 1'b1; end
      6'b000010: begin
        res_n = sub9[7:0]; c_n = sub9[8]; dc_n = sub5[4];
        c_e = 1'b1; dc_e = 1'b1; z_e = 1'b1;
      end
      6'b000011: begin res_n = operand - 8'd1; z_e = 1'b1; end
      6'b000100: begin res_n = operand | W; z_e = 1'b1; end
      6'b000101: begin res_n = operand & W; z_e = 1'b1; end
      6'b000110: begin res_n = operand ^ W; z_e = 1'b1; end
      6'b000111: begin
        res_n = add9[7:0]; c_n = add9[8]; dc_n = add5[4];
        c_e = 1'b1; dc_e = 1'b1; z_e = 1'b1;
      end
      6'b001000: z_e = 1'b1;
      6'b001001: begin res_n = ~operand; z_e = 1'b1; end
      6'b001010: begin res_n = operand + 8'd1; z_e = 1'b1; end
      6'b001011: begin res_n = operand - 8'd1; skp_n = (res_n == 8'h00); end
      6'b001100: begin res_n = {C, operand[7:1]}; c_n = operand[0]; c_e = 1'b1; end
      6'b001101: begin res_n = {operand[6:0], C}; c_n = operand[7]; c_e = 1'b1; end
      6'b001110: res_n = {operand[3:0], operand[7:4]};
      6'b001111: begin res_n = operand + 8'd1; skp_n = (res_n == 8'h00); end
      default:   wr_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      instr_q <= '0;
      eff_adr <= '0;
      operand <= '0;
      result  <= '0;
      c_q     <= 1'b0;
      dc_q    <= 1'b0;
      z_q     <= 1'b0;
      c_en_q  <= 1'b0;
      dc_en_q <= 1'b0;
      z_en_q  <= 1'b0;
      f_wr_q  <= 1'b0;
      w_wr_q  <= 1'b0;
      skip_q  <= 1'b0;
      done_q  <= 1'b0;
      W       <= '0;
    end else begin
      case (state)
        IDLE: if (instr_valid) begin
          instr_q <= instr;
          state   <= RD;
        end
        RD: begin
          eff_adr <= ea_rd;
          operand <= f_out_data;
          state   <= EX;
        end
        EX: begin
          result  <= res_n;
          c_q     <= c_n;
          dc_q    <= dc_n;
          z_q     <= (res_n == 8'h00);
          c_en_q  <= c_e;
          dc_en_q <= dc_e;
          z_en_q  <= z_e;
          // Indirect access through FSR=0 must never write address 0.
          f_wr_q  <= wr_n & d & (eff_adr != 5'd0);
          w_wr_q  <= wr_n & ~d;
          skip_q  <= skp_n;
          done_q  <= 1'b1;
          state   <= WB;
        end
        default: begin
          if (w_wr_q) W <= result;
          c_en_q  <= 1'b0;
          dc_en_q <= 1'b0;
          z_en_q  <= 1'b0;
          f_wr_q  <= 1'b0;
          w_wr_q  <= 1'b0;
          skip_q  <= 1'b0;
          done_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready = (state == IDLE) & ~rst;
  assign f_wr        = f_wr_q & ~rst;
  assign done        = done_q & ~rst;
  assign skip        = skip_q & ~rst;
  assign C_en        = c_en_q & ~rst;
  assign DC_en       = dc_en_q & ~rst;
  assign Z_en        = z_en_q & ~rst;
  assign C_new       = c_q;
  assign DC_new      = dc_q;
  assign Z_new       = z_q;
  assign f_in_data   = (!rst && state == WB) ? result : 8'h00;

  always_comb begin
    f_adrs = 5'd0;
    if (!rst) begin
      case (state)
        RD:      f_adrs = ea_rd;
        EX, WB:  f_adrs = eff_adr;
        default: f_adrs = 5'd0;
      endcase
    end
  end

endmodule

// File: doc/file_op_exec.md
FILE_OP_EXEC -- requirements
Module: file_op_exec

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: instr_valid  in  1  instruction offered.
REQ-004 SHALL have: instr  in  12  byte-oriented instruction; [11:6] opcode, [5] d, [4:0] f.
REQ-005 SHALL have: instr_ready  out  1  block can accept instruction.
REQ-006 SHALL have: fsr  in  5  current FSR value from register file.
REQ-007 SHALL have: f_out_data  in  8  asynchronous read data from register file.
REQ-008 SHALL have: C  in  1  current carry flag.
REQ-009 SHALL have: f_adrs  out  5, f_wr  out  1, f_in_data  out  8  register-file access port.
REQ-010 SHALL have: C_new, DC_new, Z_new  out  1 each  flag values; C_en, DC_en, Z_en  out  1 each  flag update strobes.
REQ-011 SHALL have: W  out  8  working register; skip  out  1  skip next instruction; done  out  1  completion pulse.

Function
REQ-012 SHALL implement FSM IDLE->RD->EX->WB->IDLE, one state per clock, no stalls.
REQ-013 instr_ready SHALL be 1 only in IDLE with rst low; instr_valid&instr_ready captures instr and moves to RD.
REQ-014 Effective address SHALL be fsr (sampled in RD) when f==0, else f; f_adrs SHALL drive it in RD, EX and WB, and 0 in IDLE.
REQ-015 RD SHALL latch f_out_data into an operand register at end of cycle; EX SHALL compute 8-bit result and flags into registers.
REQ-016 WB SHALL: d=1 -> f_wr=1, f_in_data=result for one cycle; d=0 -> W<=result at end of WB, f_wr=0.
REQ-017 f_wr SHALL be suppressed when the effective address is 0 (indirect via FSR=0).
REQ-018 done SHALL pulse 1 in WB only; latency accept-edge to done = 3 cycles; back-to-back accept allowed next IDLE cycle (4-cycle throughput).
REQ-019 Opcodes (result; flags): 000111 ADDWF f+W (C,DC,Z); 000010 SUBWF f+~W+1 (C=no borrow, DC=no nibble borrow, Z); 000101 ANDWF, 000100 IORWF, 000110 XORWF (Z); 001001 COMF ~f (Z); 000011 DECF f-1 (Z); 001010 INCF f+1 (Z); 001000 MOVF f (Z); 001101 RLF {f[6:0],C}, C_new=f[7]; 001100 RRF {C,f[7:1]}, C_new=f[0]; 001110 SWAPF {f[3:0],f[7:4]} (none); 001011 DECFSZ f-1, 001111 INCFSZ f+1 (none).
REQ-020 Opcode 000001: d=1 CLRF writes 0, d=0 CLRW loads W=0; Z_new=1, Z_en.
REQ-021 Opcode 000000: d=1 MOVWF writes W to f, no flags; d=0 NOP, no write, no W change.
REQ-022 All other opcodes SHALL complete as NOP (done pulses, no write, no flags).
REQ-023 ADDWF DC SHALL be carry out of bit 3 of f[3:0]+W[3:0]; C carry out of bit 7, 9-bit arithmetic.
REQ-024 Flag enables SHALL assert only in WB and only for flags the opcode affects; flag enables have priority over a STATUS write in the register file.
REQ-025 skip SHALL be 1 in WB for DECFSZ/INCFSZ when result==0, else 0; all counts wrap modulo 256.
REQ-026 C input SHALL be sampled in EX for RLF/RRF.

Reset
REQ-027 rst SHALL force state IDLE, W=0, operand/result=0, and f_wr, done, skip, all enables, f_adrs, f_in_data to 0 in the same cycle.
REQ-028 rst mid-operation SHALL abort without write; instr_ready=1 the first cycle after rst falls.

Verification
REQ-029 ADDWF d=1 f=0x10, W=0x0F, mem=0x01 -> WB: f_wr=1, f_adrs=0x10, f_in_data=0x10, C_new=0, DC_new=1, Z_new=0, all enables, done 3 cycles after accept.
REQ-030 SUBWF d=0, W=0x05, mem=0x05 -> W=0x00, C_new=1, DC_new=1, Z_new=1, f_wr=0.
REQ-031 INCF d=1 f=0, fsr=0x12, mem[0x12]=0xFF -> f_adrs=0x12, f_in_data=0x00, Z_new=1 with Z_en only; repeat with fsr=0 -> f_wr never 1.
REQ-032 DECFSZ d=1 f=0x08, mem=0x01 -> f_in_data=0x00, skip=1 with done, no enables; mem=0x02 -> skip=0.
REQ-033 RRF d=0, C=1, mem=0x01 -> W=0x80, C_new=1, only C_en.
REQ-034 rst asserted in EX of a d=1 write -> f_wr stays 0, W=0x00, instr_ready=1 cycle after rst deasserts.
